// File: rtl/deserializer_pkg.sv
// Shared types and sizing for the deserializer front end.
// DESERIALIZER_PARITY_EN adds an even-parity bit after each data word.
package deserializer_pkg;

  localparam int unsigned DESER_WIDTH = 8;
  localparam int unsigned DESER_CNT_W = DESER_WIDTH;

`ifdef DESERIALIZER_PARITY_EN
  localparam int unsigned DESER_BITS_PER_WORD = DESER_WIDTH + 1;
`else
  localparam int unsigned DESER_BITS_PER_WORD = DESER_WIDTH;
`endif

  typedef enum logic [0:0] {
    COLLECT  = 1'b0,
    WAIT_ACK = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_shift_reg.sv
// Left-shift register: new bit enters at the LSB, so the first bit ends up at the MSB.
module deser_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel front end: MSB-first word assembly with a ready/ack handshake.
// Optional DESERIALIZER_PARITY_EN: trailing even-parity bit, bad words dropped with a pulse.
module deserializer
  import deserializer_pkg::*;
(
  input  logic                   clock_100,
  input  logic                   reset,
  input  logic                   data_in,
  input  logic                   write_in,
  input  logic                   ack_in,
  output logic [DESER_WIDTH-1:0] data_out,
  output logic                   data_ready,
  output logic                   status_out
`ifdef DESERIALIZER_PARITY_EN
  ,
  output logic                   parity_err_out
`endif
);

  localparam int unsigned WIDTH = DESER_WIDTH;
  localparam int unsigned CNT_W = DESER_CNT_W;

  deser_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] data_out_nxt;
  logic             data_ready_nxt;
  logic             status_nxt;
  logic             shift_en;
  logic             shift_clr;
  logic [WIDTH-1:0] sr_q;
`ifdef DESERIALIZER_PARITY_EN
  logic             parity_err_nxt;
`endif

  // Shift register is cleared by reset as well as after each completed word.
  deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clock_100),
    .clear    (shift_clr | ~reset),
    .shift_en (shift_en),
    .din      (data_in),
    .q        (sr_q)
  );

  always_ff @(posedge clock_100) begin
    if (!reset) begin
      state      <= COLLECT;
      cnt        <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      status_out <= 1'b1;
`ifdef DESERIALIZER_PARITY_EN
      parity_err_out <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      data_out   <= data_out_nxt;
      data_ready <= data_ready_nxt;
      status_out <= status_nxt;
`ifdef DESERIALIZER_PARITY_EN
      parity_err_out <= parity_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    data_out_nxt   = data_out;
    data_ready_nxt = data_ready;
    status_nxt     = status_out;
    shift_en       = 1'b0;
    shift_clr      = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
    parity_err_nxt = 1'b0;
`endif
    unique case (state)
      COLLECT: begin
        if (write_in) begin
`ifdef DESERIALIZER_PARITY_EN
          // Data bits are already in the register; this bit is parity only.
          if (cnt == CNT_W'(WIDTH)) begin
            cnt_nxt   = '0;
            shift_clr = 1'b1;
            if ((^sr_q) == data_in) begin
              data_out_nxt   = sr_q;
              data_ready_nxt = 1'b1;
              status_nxt     = 1'b0;
              state_nxt      = WAIT_ACK;
            end else begin
              parity_err_nxt = 1'b1;
            end
          end else begin
            shift_en = 1'b1;
            cnt_nxt  = cnt + CNT_W'(1);
          end
`else
          // Last bit bypasses the register straight into the output word.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt_nxt        = '0;
            shift_clr      = 1'b1;
            data_out_nxt   = {sr_q[WIDTH-2:0], data_in};
            data_ready_nxt = 1'b1;
            status_nxt     = 1'b0;
            state_nxt      = WAIT_ACK;
          end else begin
            shift_en = 1'b1;
            cnt_nxt  = cnt + CNT_W'(1);
          end
`endif
        end
      end
      WAIT_ACK: begin
        if (ack_in) begin
          data_ready_nxt = 1'b0;
          status_nxt     = 1'b1;
          state_nxt      = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed scenarios plus random traffic against a queue-based model.
module tb_deserializer;
  import deserializer_pkg::*;

`ifdef DESERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clock_100 = 1'b0;
  logic       reset, data_in, write_in, ack_in;
  logic [7:0] data_out;
  logic       data_ready, status_out;
  logic       parity_err_dut;

  always #5 clock_100 = ~clock_100;

  deserializer dut (
    .clock_100  (clock_100),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .ack_in     (ack_in),
    .data_out   (data_out),
    .data_ready (data_ready),
    .status_out (status_out)
`ifdef DESERIALIZER_PARITY_EN
    ,
    .parity_err_out (parity_err_dut)
`endif
  );

`ifndef DESERIALIZER_PARITY_EN
  assign parity_err_dut = 1'b0;
`endif

  // Reference model state
  bit         m_bits[$];
  logic [7:0] m_dout;
  bit         m_ready, m_status, m_perr;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  bit prev_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(input bit rst, input bit din, input bit wr, input bit ack);
    logic [7:0] w;
    bit         ok;
    m_perr = 1'b0;
    if (!rst) begin
      m_bits.delete();
      m_dout   = 8'h00;
      m_ready  = 1'b0;
      m_status = 1'b1;
    end else if (m_ready) begin
      if (ack) begin
        m_ready  = 1'b0;
        m_status = 1'b1;
      end
    end else if (wr) begin
      m_bits.push_back(din);
      if (m_bits.size() == NB) begin
        w = 8'h00;
        for (int i = 0; i < 8; i++) if (m_bits[i]) w = w + 8'(1 << (7 - i));
        ok = 1'b1;
`ifdef DESERIALIZER_PARITY_EN
        ok = ((($countones(w) + int'(m_bits[8])) % 2) == 0);
`endif
        if (ok) begin
          m_dout   = w;
          m_ready  = 1'b1;
          m_status = 1'b0;
        end else begin
          m_perr = 1'b1;
        end
        m_bits.delete();
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare just after the edge.
  task automatic step(input bit rst, input bit din, input bit wr, input bit ack);
    reset    = rst;
    data_in  = din;
    write_in = wr;
    ack_in   = ack;
    @(posedge clock_100);
    model_step(rst, din, wr, ack);
    #1;
    if (data_ready && !prev_ready) pulses++;
    prev_ready = data_ready;
    check("data_out", 32'(data_out), 32'(m_dout));
    check("data_ready", 32'(data_ready), 32'(m_ready));
    check("status_out", 32'(status_out), 32'(m_status));
`ifdef DESERIALIZER_PARITY_EN
    check("parity_err_out", 32'(parity_err_dut), 32'(m_perr));
`endif
  endtask

  task automatic send_word(input logic [7:0] w, input bit par_ok);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b1, 1'b0);
`ifdef DESERIALIZER_PARITY_EN
    step(1'b1, (^w) ^ !par_ok, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    int base;
    bit r, wr, ak, d;

    // Reset held two cycles
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_ready", 32'(data_ready), 32'h0);
    check("rst_status", 32'(status_out), 32'h1);

    // 0xA5 and its handshake
    send_word(8'hA5, 1'b1);
    check("a5_ready", 32'(data_ready), 32'h1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_status", 32'(status_out), 32'h0);

    // Bits sent while stalled are dropped
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("stall_hold", 32'(data_out), 32'hA5);
    check("stall_ready", 32'(data_ready), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("ack_ready", 32'(data_ready), 32'h0);
    check("ack_status", 32'(status_out), 32'h1);
    send_word(8'h3C, 1'b1);
    check("after_drop", 32'(data_out), 32'h3C);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Partial word discarded by reset
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h0F, 1'b1);
    check("partial_reset", 32'(data_out), 32'h0F);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Nine back-to-back words with a held ack level between them
    base = pulses;
    for (int k = 1; k <= 9; k++) begin
      send_word(8'(k * 8'h11), 1'b1);
      check("word_seq", 32'(data_out), 32'(k * 8'h11));
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    check("nine_pulses", 32'(pulses - base), 32'd9);

`ifdef DESERIALIZER_PARITY_EN
    send_word(8'hA5, 1'b0);
    check("par_err_pulse", 32'(parity_err_dut), 32'h1);
    check("par_err_ready", 32'(data_ready), 32'h0);
    check("par_err_status", 32'(status_out), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("par_err_clear", 32'(parity_err_dut), 32'h0);
`endif

    // Random traffic: occasional resets, bursty writes, sporadic acks
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 149) != 0);
      wr = ($urandom_range(0, 3) != 0);
      ak = ($urandom_range(0, 4) == 0);
      d  = 1'($urandom_range(0, 1));
      step(r, d, wr, ak);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
